// File: rtl/lcd_px_sink.sv
// Pixel sink for the PPU stream: packs four 2-bit shades per byte and writes them
// into a double-buffered 160x144 framebuffer, swapping banks after V-blank.
module lcd_px_sink #(
    parameter int FIFO_DEPTH = 8,
    parameter int FB_AW      = 14,
    parameter int BANK1_BASE = 5760
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       PX_OUT,
    input  logic             PX_valid,
    input  logic [1:0]       PPU_MODE,
    input  logic             LCD_EN,
    output logic             FB_WE,
    output logic [FB_AW-1:0] FB_ADDR,
    output logic [7:0]       FB_DATA,
    input  logic             FB_READY,
    output logic             DISP_BANK,
    output logic             FRAME_DONE,
    output logic             OVF,
    output logic             FRAME_ERR
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PW:0]       DEPTH_C = FIFO_DEPTH[PW:0];
    localparam logic [FB_AW-1:0]  BANK1   = BANK1_BASE[FB_AW-1:0];

    logic [7:0]       x, y;
    logic [5:0]       pack;
    logic             swap_pending, addr_bank, disp_bank, frame_done;
    logic             ovf, frame_err, prev_vb, lcd_en_q;
    logic [FB_AW-1:0] mem_addr [FIFO_DEPTH];
    logic [7:0]       mem_data [FIFO_DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [PW:0]      count;

    logic             mode_vb, px_live, accept, late_px, vb_entry, lcd_fall;
    logic             pack_done, pop, push_ok, push_drop;
    logic [FB_AW-1:0] bank_base, y_ext, push_addr;
    logic [7:0]       push_byte;

    always_comb begin
        mode_vb   = (PPU_MODE == 2'd1);
        px_live   = PX_valid && LCD_EN && !mode_vb;
        accept    = px_live && (y < 8'd144);
        late_px   = px_live && (y == 8'd144);
        vb_entry  = mode_vb && !prev_vb && LCD_EN;
        lcd_fall  = lcd_en_q && !LCD_EN;
        pack_done = accept && (x[1:0] == 2'b11);
        // Write port: FB_WE is valid, a beat moves on any edge with FB_WE && FB_READY,
        // and the head entry is held unchanged in the FIFO until that edge.
        pop       = (count != '0) && FB_READY;
        push_ok   = pack_done && ((count < DEPTH_C) || pop);
        push_drop = pack_done && !push_ok;
        bank_base = addr_bank ? BANK1 : '0;
        y_ext     = {{(FB_AW-8){1'b0}}, y};
        push_addr = bank_base + (y_ext << 5) + (y_ext << 3) + {{(FB_AW-6){1'b0}}, x[7:2]};
        push_byte = {pack, PX_OUT};
    end

    // Frame geometry, packing and bank control.
    always_ff @(posedge clk) begin
        if (rst) begin
            x            <= '0;
            y            <= '0;
            pack         <= '0;
            swap_pending <= 1'b0;
            addr_bank    <= 1'b1;
            disp_bank    <= 1'b0;
            frame_done   <= 1'b0;
            frame_err    <= 1'b0;
            prev_vb      <= 1'b1;
            lcd_en_q     <= 1'b0;
        end else begin
            prev_vb    <= mode_vb;
            lcd_en_q   <= LCD_EN;
            frame_done <= 1'b0;
            if (lcd_fall) begin
                x            <= '0;
                y            <= '0;
                pack         <= '0;
                swap_pending <= 1'b0;
                addr_bank    <= ~disp_bank;
            end else if (vb_entry) begin
                if ((y != 8'd144) || (x != 8'd0))
                    frame_err <= 1'b1;
                swap_pending <= 1'b1;
                x            <= '0;
                y            <= '0;
                pack         <= '0;
                // New pixels target the bank the display is about to release.
                addr_bank    <= disp_bank;
            end else begin
                if (accept) begin
                    case (x[1:0])
                        2'd0:    pack[5:4] <= PX_OUT;
                        2'd1:    pack[3:2] <= PX_OUT;
                        2'd2:    pack[1:0] <= PX_OUT;
                        default: ;
                    endcase
                    if (x == 8'd159) begin
                        x <= '0;
                        y <= y + 8'd1;
                    end else begin
                        x <= x + 8'd1;
                    end
                end
                if (late_px)
                    frame_err <= 1'b1;
                if (swap_pending && (count == '0)) begin
                    disp_bank    <= ~disp_bank;
                    frame_done   <= 1'b1;
                    swap_pending <= 1'b0;
                end
            end
        end
    end

    // Packed-byte write FIFO; the head lives in registers and drives the port directly.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_addr[i] <= '0;
                mem_data[i] <= '0;
            end
        end else begin
            if (push_ok) begin
                mem_addr[wr_ptr] <= push_addr;
                mem_data[wr_ptr] <= push_byte;
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push_drop)
                ovf <= 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    assign FB_WE      = (count != '0);
    assign FB_ADDR    = mem_addr[rd_ptr];
    assign FB_DATA    = mem_data[rd_ptr];
    assign DISP_BANK  = disp_bank;
    assign FRAME_DONE = frame_done;
    assign OVF        = ovf;
    assign FRAME_ERR  = frame_err;

endmodule

// File: tb/tb_lcd_px_sink.sv
// Directed bench for lcd_px_sink: full frames, stalls, overflow, LCD-off and
// short-frame cases, with every framebuffer write checked against an expected queue.
module tb_lcd_px_sink;

    localparam int FB_AW = 14;
    localparam int BANK1 = 5760;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       PX_OUT;
    logic             PX_valid;
    logic [1:0]       PPU_MODE;
    logic             LCD_EN;
    logic             FB_WE;
    logic [FB_AW-1:0] FB_ADDR;
    logic [7:0]       FB_DATA;
    logic             FB_READY;
    logic             DISP_BANK, FRAME_DONE, OVF, FRAME_ERR;

    int n_checks = 0;
    int n_errors = 0;
    int xfers    = 0;
    int dones    = 0;
    logic [21:0] exp_q[$];

    lcd_px_sink #(.FIFO_DEPTH(8), .FB_AW(FB_AW), .BANK1_BASE(BANK1)) dut (
        .clk(clk), .rst(rst), .PX_OUT(PX_OUT), .PX_valid(PX_valid),
        .PPU_MODE(PPU_MODE), .LCD_EN(LCD_EN), .FB_WE(FB_WE), .FB_ADDR(FB_ADDR),
        .FB_DATA(FB_DATA), .FB_READY(FB_READY), .DISP_BANK(DISP_BANK),
        .FRAME_DONE(FRAME_DONE), .OVF(OVF), .FRAME_ERR(FRAME_ERR)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard: every transfer must match the head of the expected queue
    always @(negedge clk) begin
        if (!rst) begin
            if (FRAME_DONE) begin
                dones++;
                check_eq("done_after_drain", exp_q.size() + int'(FB_WE), 0);
            end
            if (FB_WE && FB_READY) begin
                xfers++;
                if (exp_q.size() == 0)
                    check_eq("write_with_empty_queue", exp_q.size(), 1);
                else
                    check_eq("write", {FB_ADDR, FB_DATA}, exp_q.pop_front());
            end
        end
    end

    // Driver tasks
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pixel(input logic [1:0] s);
        PX_OUT   = s;
        PX_valid = 1'b1;
        cyc();
        PX_valid = 1'b0;
    endtask

    task automatic expect_wr(input int addr, input logic [7:0] d);
        logic [13:0] a;
        a = addr[13:0];
        exp_q.push_back({a, d});
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        PX_valid = 1'b0;
        PX_OUT   = 2'd0;
        PPU_MODE = 2'd3;
        LCD_EN   = 1'b1;
        FB_READY = 1'b1;
        repeat (3) cyc();
        exp_q.delete();
        rst = 1'b0;
        cyc();
    endtask

    task automatic send_lines(input int lines, input bit solid, input int base);
        for (int yy = 0; yy < lines; yy++) begin
            for (int xx = 0; xx < 160; xx++) begin
                pixel(solid ? 2'd3 : 2'(xx % 4));
                if (xx % 4 == 3)
                    expect_wr(base + yy * 40 + xx / 4, solid ? 8'hFF : 8'h1B);
            end
        end
    endtask

    // V-blank with a short write stall and stray pixels that must be ignored
    task automatic vblank();
        PPU_MODE = 2'd1;
        FB_READY = 1'b0;
        PX_OUT   = 2'd2;
        PX_valid = 1'b1;
        repeat (5) cyc();
        PX_valid = 1'b0;
        FB_READY = 1'b1;
        repeat (30) cyc();
        PPU_MODE = 2'd3;
        cyc();
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || FB_WE) && n < budget) begin
            cyc();
            n++;
        end
        check_eq("drain", exp_q.size(), 0);
    endtask

    initial begin
        int x0, d0;
        bit stable;

        do_reset();
        check_eq("rst_fb_we", FB_WE, 0);
        check_eq("rst_fb_addr", FB_ADDR, 0);
        check_eq("rst_fb_data", FB_DATA, 0);
        check_eq("rst_disp_bank", DISP_BANK, 0);
        check_eq("rst_frame_done", FRAME_DONE, 0);
        check_eq("rst_ovf", OVF, 0);
        check_eq("rst_frame_err", FRAME_ERR, 0);

        // Partial line up to x=37, then LCD off: bytes 0..8 land, x=36..37 is lost
        for (int xx = 0; xx < 38; xx++) begin
            pixel(2'(xx % 4));
            if (xx % 4 == 3)
                expect_wr(BANK1 + xx / 4, 8'h1B);
        end
        LCD_EN   = 1'b0;
        PX_OUT   = 2'd1;
        PX_valid = 1'b1;
        repeat (3) cyc();
        PX_valid = 1'b0;
        repeat (2) cyc();
        LCD_EN = 1'b1;
        cyc();
        wait_drain(20);
        check_eq("lcd_off_err", FRAME_ERR, 0);
        check_eq("lcd_off_bank", DISP_BANK, 0);

        // Frame 1: shade = x%4 into bank 1
        x0 = xfers;
        d0 = dones;
        send_lines(144, 1'b0, BANK1);
        vblank();
        check_eq("f1_writes", xfers - x0, 5760);
        check_eq("f1_done", dones - d0, 1);
        check_eq("f1_bank", DISP_BANK, 1);
        check_eq("f1_err", FRAME_ERR, 0);
        check_eq("f1_ovf", OVF, 0);

        // Frame 2: solid shade 3 into bank 0
        x0 = xfers;
        d0 = dones;
        send_lines(144, 1'b1, 0);
        vblank();
        check_eq("f2_writes", xfers - x0, 5760);
        check_eq("f2_done", dones - d0, 1);
        check_eq("f2_bank", DISP_BANK, 0);
        check_eq("f2_err", FRAME_ERR, 0);

        // Short frame: 100 lines then V-blank
        d0 = dones;
        send_lines(100, 1'b0, BANK1);
        vblank();
        check_eq("short_err", FRAME_ERR, 1);
        check_eq("short_bank", DISP_BANK, 1);
        check_eq("short_done", dones - d0, 1);
        for (int i = 0; i < 4; i++)
            pixel(2'd3);
        expect_wr(0, 8'hFF);
        wait_drain(20);

        // Stall: 10 bytes against an 8-deep FIFO
        do_reset();
        FB_READY = 1'b0;
        stable   = 1'b1;
        for (int i = 0; i < 40; i++) begin
            pixel(2'(i % 4));
            if (i % 4 == 3 && i / 4 < 8)
                expect_wr(BANK1 + i / 4, 8'h1B);
            if (FB_WE && FB_ADDR != 14'(BANK1))
                stable = 1'b0;
        end
        check_eq("stall_ovf", OVF, 1);
        check_eq("stall_we", FB_WE, 1);
        check_eq("stall_addr", FB_ADDR, BANK1);
        check_eq("stall_addr_stable", stable, 1);
        check_eq("stall_data", FB_DATA, 8'h1B);
        x0 = xfers;
        FB_READY = 1'b1;
        wait_drain(40);
        check_eq("stall_writes", xfers - x0, 8);

        // Push and pop on the same edge while full
        do_reset();
        FB_READY = 1'b0;
        for (int i = 0; i < 35; i++) begin
            pixel(2'(i % 4));
            if (i % 4 == 3)
                expect_wr(BANK1 + i / 4, 8'h1B);
        end
        check_eq("full_ovf_before", OVF, 0);
        FB_READY = 1'b1;
        pixel(2'd3);
        expect_wr(BANK1 + 8, 8'h1B);
        FB_READY = 1'b0;
        check_eq("full_ovf_after", OVF, 0);
        check_eq("full_head", FB_ADDR, BANK1 + 1);
        repeat (2) cyc();
        x0 = xfers;
        FB_READY = 1'b1;
        wait_drain(40);
        check_eq("full_writes", xfers - x0, 8);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/lcd_px_sink.md
Name: lcd_px_sink

Overview:
- Consumer end of the PPU pixel stream: accepts one 2-bit shade per PX_valid and packs 4 pixels per byte.
- Writes packed bytes into a double-buffered 160x144 framebuffer through a write port with a ready handshake.
- Swaps banks at V-blank so the display reader (VGA/HPS side) always scans a complete frame.
- Sits between the PPU3 pixel output and the framebuffer RAM, and uses the PPU mode output for frame sync.

Parameters:
- FIFO_DEPTH, 8: entries in the packed-byte write FIFO (power of 2, ≥2).
- FB_AW, 14: framebuffer byte-address width.
- BANK1_BASE, 5760: byte address of bank 1. Bank 0 is at 0. One bank is 40 bytes/line x 144 lines.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- PX_OUT  in  2  pixel shade from PPU.
- PX_valid  in  1  PX_OUT valid this cycle.
- PPU_MODE  in  2  0=H_BLANK, 1=V_BLANK, 2=SCAN, 3=DRAW.
- LCD_EN  in  1  LCDC[7]; low = display off.
- FB_WE  out  1  write request valid.
- FB_ADDR  out  FB_AW  framebuffer byte address.
- FB_DATA  out  8  packed pixels; pixel x%4==0 in [7:6], x%4==3 in [1:0].
- FB_READY  in  1  framebuffer accepts the write this cycle.
- DISP_BANK  out  1  bank the display must read.
- FRAME_DONE  out  1  one-cycle pulse when a bank swap occurs.
- OVF  out  1  sticky: packed byte dropped because the FIFO was full.
- FRAME_ERR  out  1  sticky: frame geometry violation.

Behaviour:
- Reset: FB_WE=0, FB_ADDR=0, FB_DATA=0, DISP_BANK=0, FRAME_DONE=0, OVF=0, FRAME_ERR=0. Also x=0, y=0, pack register=0, FIFO empty, swap_pending=0. Write bank = ~DISP_BANK. Reset mid-frame discards all partial and queued data.
- Counters: x in 0..159 (8 bit), y in 0..143 (8 bit).
- Accepted pixel: PX_valid=1 AND LCD_EN=1 AND PPU_MODE!=1 AND y<144.
  - Each accepted pixel writes PX_OUT into pack slot x[1:0].
  - x increments. At x=159 it wraps to 0 and y increments.
- PX_valid=1 with y==144 (before V-blank): pixel dropped, FRAME_ERR set.
- PX_valid=1 in V_BLANK or with LCD_EN=0: ignored, no error.
- Pack complete: when the pixel with x[1:0]==3 is accepted, push {addr, byte} into the FIFO on the same edge.
  - addr = bankbase + y*40 + x[7:2], computed at FB_AW width.
  - byte = the three held slots plus the current PX_OUT.
  - Push latency: pixel → FIFO entry 1 cycle; FB_WE no earlier than 1 cycle later.
- FIFO full on push: entry dropped, OVF set, x/y still advance.
- Push and pop in the same cycle are legal, including when full: pop frees a slot, push succeeds, no OVF.
- Write handshake:
  - FB_WE=1 whenever the FIFO is non-empty; FB_ADDR/FB_DATA show the head entry.
  - Transfer occurs on an edge with FB_WE&&FB_READY.
  - FB_ADDR/FB_DATA must stay stable while FB_WE=1 and FB_READY=0.
  - The next entry is presented the cycle after a transfer (registered head); FB_WE drops when the FIFO empties.
- V-blank entry: the cycle PPU_MODE becomes 1 from a non-1 value.
  - If (y!=144 or x!=0): set FRAME_ERR.
  - Set swap_pending; x,y reset to 0; pack register cleared.
- Bank swap: when swap_pending=1 and the FIFO is empty with no transfer in flight:
  - DISP_BANK toggles (write bank follows as its inverse).
  - FRAME_DONE pulses for one cycle; swap_pending clears.
  - Swap may complete during V-blank or later; queued bytes always land in the old write bank.
- New pixels after V-blank while swap_pending=1 go into the FIFO tagged with the new bank's addresses.
  - Bank selection for address generation switches at V-blank entry, not at the swap.
- LCD_EN falling: x,y, pack register and swap_pending cleared. FIFO keeps draining. No error, no swap, DISP_BANK held.
- Counter wrap: y never exceeds 144; x never exceeds 159.

Test Plan:
- Reset, stream 160x144 pixels PX_OUT=(x%4) with FB_READY=1, then PPU_MODE→1:
  - 5760 writes to addresses 5760..11519, all data 8'h1B.
  - Exactly one FRAME_DONE; DISP_BANK 0→1; FRAME_ERR=0, OVF=0.
- Second full frame with PX_OUT=3:
  - Writes to 0..5759, data 8'hFF.
  - DISP_BANK back to 0; FRAME_DONE fires only after the last FB_WE&&FB_READY.
- FB_READY=0 for 40 cycles while 40 pixels (10 bytes) arrive, FIFO_DEPTH=8:
  - OVF=1; 8 entries held stable, FB_ADDR=5760 stable throughout stall.
  - After release, addresses 5760..5767 written, 5768/5769 absent.
- V-blank entry after 100 lines: FRAME_ERR=1; bank still swaps once FIFO drains; next frame starts at y=0 address base.
- LCD_EN low mid-line (x=37), then high and a full frame:
  - No write of the partial byte at x=36..37; first write of the new frame at the write-bank base; FRAME_ERR=0.
- Push on the same edge as a pop with FIFO full: no OVF, occupancy unchanged, order preserved.
